// File: rtl/reorder_buffer_pkg.sv
// Shared widths for the reorder buffer and its pipeline-facing interface.
package reorder_buffer_pkg;

  localparam int DEF_ROB_WIDTH = 4;
  localparam int DEF_REG_WIDTH = 32;
  localparam int RD_WIDTH      = 5;

  typedef logic [RD_WIDTH-1:0] rd_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Issue, write-back, operand-query and commit-broadcast signals of the reorder buffer.
interface reorder_buffer_if
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_WIDTH = DEF_ROB_WIDTH,
  parameter int REG_WIDTH = DEF_REG_WIDTH
);

  logic                 issue;
  rd_t                  issue_rd;
  logic                 issue_is_branch;
  logic                 issue_pred_taken;
  logic [ROB_WIDTH-1:0] issue_tag;
  logic                 full;

  logic                 done_alu_1;
  logic                 done_alu_2;
  logic [REG_WIDTH-1:0] value_alu_1;
  logic [REG_WIDTH-1:0] value_alu_2;
  logic [ROB_WIDTH-1:0] tag_alu_1;
  logic [ROB_WIDTH-1:0] tag_alu_2;

  logic [ROB_WIDTH-1:0] query_tag_1;
  logic [ROB_WIDTH-1:0] query_tag_2;
  logic                 query_ready_1;
  logic                 query_ready_2;
  logic [REG_WIDTH-1:0] query_value_1;
  logic [REG_WIDTH-1:0] query_value_2;

  logic                 commit;
  logic [ROB_WIDTH-1:0] commit_tag;
  logic [REG_WIDTH-1:0] commit_value;
  rd_t                  commit_rd;
  logic                 clear_signal;

  modport slave (
    input  issue, issue_rd, issue_is_branch, issue_pred_taken,
    input  done_alu_1, done_alu_2, value_alu_1, value_alu_2, tag_alu_1, tag_alu_2,
    input  query_tag_1, query_tag_2,
    output issue_tag, full,
    output query_ready_1, query_ready_2, query_value_1, query_value_2,
    output commit, commit_tag, commit_value, commit_rd, clear_signal
  );

  modport master (
    output issue, issue_rd, issue_is_branch, issue_pred_taken,
    output done_alu_1, done_alu_2, value_alu_1, value_alu_2, tag_alu_1, tag_alu_2,
    output query_tag_1, query_tag_2,
    input  issue_tag, full,
    input  query_ready_1, query_ready_2, query_value_1, query_value_2,
    input  commit, commit_tag, commit_value, commit_rd, clear_signal
  );

endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates tags, collects ALU results, retires in order
// and flushes everything when a mispredicted branch retires.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_WIDTH = DEF_ROB_WIDTH,
  parameter int ROB_SIZE  = 2 ** ROB_WIDTH,
  parameter int REG_WIDTH = DEF_REG_WIDTH
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  reorder_buffer_if.slave  bus
);

  typedef logic [ROB_WIDTH-1:0] tag_t;

  localparam tag_t               LAST_IDX = tag_t'(ROB_SIZE - 1);
  localparam logic [ROB_WIDTH:0] SIZE_CNT = (ROB_WIDTH + 1)'(ROB_SIZE);

  logic [ROB_SIZE-1:0]  busy;
  logic [ROB_SIZE-1:0]  ready;
  logic [ROB_SIZE-1:0]  is_branch;
  logic [ROB_SIZE-1:0]  pred_taken;
  logic [REG_WIDTH-1:0] value [ROB_SIZE];
  rd_t                  rd    [ROB_SIZE];

  tag_t               head;
  tag_t               tail;
  logic [ROB_WIDTH:0] count;

  logic do_issue;
  logic do_commit;
  logic mispredict;
  logic wb1_hit;
  logic wb2_hit;

  function automatic tag_t next_idx(input tag_t idx);
    return (idx == LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  // Stored result first; otherwise forward a same-cycle write-back, port 1 before port 2.
  function automatic logic [REG_WIDTH:0] lookup(input tag_t t);
    logic [REG_WIDTH:0] res;
    res = {1'b0, value[t]};
    if (busy[t]) begin
      if (ready[t])
        res = {1'b1, value[t]};
      else if (bus.done_alu_1 && bus.tag_alu_1 == t)
        res = {1'b1, bus.value_alu_1};
      else if (bus.done_alu_2 && bus.tag_alu_2 == t)
        res = {1'b1, bus.value_alu_2};
    end
    return res;
  endfunction

  assign bus.full      = (count == SIZE_CNT);
  assign bus.issue_tag = tail;

  assign do_issue   = bus.issue && !bus.full;
  assign do_commit  = busy[head] && ready[head];
  assign mispredict = do_commit && is_branch[head] && (value[head][0] != pred_taken[head]);
  assign wb1_hit    = bus.done_alu_1 && busy[bus.tag_alu_1] && !ready[bus.tag_alu_1];
  assign wb2_hit    = bus.done_alu_2 && busy[bus.tag_alu_2] && !ready[bus.tag_alu_2];

  assign {bus.query_ready_1, bus.query_value_1} = lookup(bus.query_tag_1);
  assign {bus.query_ready_2, bus.query_value_2} = lookup(bus.query_tag_2);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy             <= '0;
      ready            <= '0;
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      bus.commit       <= 1'b0;
      bus.clear_signal <= 1'b0;
      bus.commit_tag   <= '0;
      bus.commit_value <= '0;
      bus.commit_rd    <= '0;
    end else if (rdy_in) begin
      bus.commit       <= do_commit;
      bus.clear_signal <= mispredict;
      if (do_commit) begin
        bus.commit_tag   <= head;
        bus.commit_value <= value[head];
        bus.commit_rd    <= is_branch[head] ? '0 : rd[head];
      end
      if (mispredict) begin
        busy  <= '0;
        ready <= '0;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        // Port 2 is written first so a port 1 hit on the same tag overrides it.
        if (wb2_hit) ready[bus.tag_alu_2] <= 1'b1;
        if (wb1_hit) ready[bus.tag_alu_1] <= 1'b1;
        if (do_commit) begin
          busy[head]  <= 1'b0;
          ready[head] <= 1'b0;
          head        <= next_idx(head);
        end
        if (do_issue) begin
          busy[tail]  <= 1'b1;
          ready[tail] <= 1'b0;
          tail        <= next_idx(tail);
        end
        case ({do_issue, do_commit})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Payload storage needs no reset: busy/ready gate every read of it.
  always_ff @(posedge clk_in) begin
    if (rdy_in && !mispredict) begin
      if (wb2_hit) value[bus.tag_alu_2] <= bus.value_alu_2;
      if (wb1_hit) value[bus.tag_alu_1] <= bus.value_alu_1;
      if (do_issue) begin
        rd[tail]         <= bus.issue_rd;
        is_branch[tail]  <= bus.issue_is_branch;
        pred_taken[tail] <= bus.issue_pred_taken;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer, checked every cycle against a program-order queue model.
module tb_reorder_buffer;

  logic clk;
  logic rst_in;
  logic rdy_in;
  bit   en_cmp;

  int check_count;
  int pass_count;

  reorder_buffer_if #(.ROB_WIDTH(4), .REG_WIDTH(32)) bus ();

  reorder_buffer dut (
    .clk_in (clk),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  tag;
    logic [4:0]  rd;
    logic        br;
    logic        pred;
    logic        rdy;
    logic [31:0] val;
  } ent_t;

  ent_t        q[$];
  logic [3:0]  m_tail;
  logic        m_commit;
  logic        m_clear;
  logic [3:0]  m_ctag;
  logic [31:0] m_cval;
  logic [4:0]  m_crd;
  int          m_size;
  bit          m_c;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // First matching not-yet-ready entry takes the result; later hits are ignored.
  function automatic void model_wb(input logic d, input logic [3:0] t, input logic [31:0] v);
    if (!d) return;
    foreach (q[i]) if (q[i].tag == t && !q[i].rdy) begin
      q[i].rdy = 1'b1;
      q[i].val = v;
    end
  endfunction

  function automatic logic [32:0] model_query(input logic [3:0] t);
    foreach (q[i]) if (q[i].tag == t) begin
      if (q[i].rdy) return {1'b1, q[i].val};
      if (bus.done_alu_1 && bus.tag_alu_1 == t) return {1'b1, bus.value_alu_1};
      if (bus.done_alu_2 && bus.tag_alu_2 == t) return {1'b1, bus.value_alu_2};
      return 33'd0;
    end
    return 33'd0;
  endfunction

  always @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      q.delete();
      m_tail   = 4'd0;
      m_commit = 1'b0;
      m_clear  = 1'b0;
      m_ctag   = 4'd0;
      m_cval   = 32'd0;
      m_crd    = 5'd0;
    end else if (rdy_in) begin
      m_size   = q.size();
      m_c      = (m_size > 0) && q[0].rdy;
      m_commit = m_c;
      m_clear  = 1'b0;
      if (m_c) begin
        m_ctag  = q[0].tag;
        m_cval  = q[0].val;
        m_crd   = q[0].br ? 5'd0 : q[0].rd;
        m_clear = q[0].br && (q[0].val[0] != q[0].pred);
      end
      if (m_clear) begin
        q.delete();
        m_tail = 4'd0;
      end else begin
        model_wb(bus.done_alu_1, bus.tag_alu_1, bus.value_alu_1);
        model_wb(bus.done_alu_2, bus.tag_alu_2, bus.value_alu_2);
        if (m_c) void'(q.pop_front());
        if (bus.issue && m_size < 16) begin
          q.push_back('{tag: m_tail, rd: bus.issue_rd, br: bus.issue_is_branch,
                        pred: bus.issue_pred_taken, rdy: 1'b0, val: 32'd0});
          m_tail = m_tail + 4'd1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (en_cmp) begin
      logic [32:0] e1;
      logic [32:0] e2;
      e1 = model_query(bus.query_tag_1);
      e2 = model_query(bus.query_tag_2);
      checkOutput("issue_tag", bus.issue_tag, m_tail);
      checkOutput("full", bus.full, q.size() == 16);
      checkOutput("commit", bus.commit, m_commit);
      checkOutput("clear_signal", bus.clear_signal, m_clear);
      checkOutput("commit_tag", bus.commit_tag, m_ctag);
      checkOutput("commit_value", bus.commit_value, m_cval);
      checkOutput("commit_rd", bus.commit_rd, m_crd);
      checkOutput("query_ready_1", bus.query_ready_1, e1[32]);
      checkOutput("query_ready_2", bus.query_ready_2, e2[32]);
      if (e1[32]) checkOutput("query_value_1", bus.query_value_1, e1[31:0]);
      if (e2[32]) checkOutput("query_value_2", bus.query_value_2, e2[31:0]);
    end
  end

  task automatic applyStimulus();
    @(posedge clk);
    #2;
  endtask

  task automatic setIdle();
    bus.issue            = 1'b0;
    bus.issue_rd         = 5'd0;
    bus.issue_is_branch  = 1'b0;
    bus.issue_pred_taken = 1'b0;
    bus.done_alu_1       = 1'b0;
    bus.done_alu_2       = 1'b0;
    bus.value_alu_1      = 32'd0;
    bus.value_alu_2      = 32'd0;
    bus.tag_alu_1        = 4'd0;
    bus.tag_alu_2        = 4'd0;
    bus.query_tag_1      = 4'd0;
    bus.query_tag_2      = 4'd0;
  endtask

  task automatic doReset();
    rst_in = 1'b1;
    #1;
    rst_in = 1'b0;
  endtask

  task automatic issueN(input int n);
    for (int i = 0; i < n; i++) begin
      bus.issue    = 1'b1;
      bus.issue_rd = 5'(i + 1);
      applyStimulus();
    end
    setIdle();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    check_count = 0;
    pass_count  = 0;
    en_cmp      = 1'b0;
    rdy_in      = 1'b1;
    rst_in      = 1'b1;
    setIdle();
    repeat (2) applyStimulus();
    rst_in = 1'b0;
    en_cmp = 1'b1;
    #1;
    checkOutput("reset_issue_tag", bus.issue_tag, 4'd0);
    checkOutput("reset_full", bus.full, 1'b0);
    checkOutput("reset_commit", bus.commit, 1'b0);

    // Reset then issue three entries
    for (int i = 0; i < 3; i++) begin
      bus.issue    = 1'b1;
      bus.issue_rd = 5'(i + 1);
      #1;
      checkOutput("issue_tag_seq", bus.issue_tag, 4'(i));
      applyStimulus();
    end
    setIdle();
    #1;
    checkOutput("issue_tag_after3", bus.issue_tag, 4'd3);
    checkOutput("no_commit_after_issue", bus.commit, 1'b0);

    // Out-of-order write-back, in-order retire, with a stall holding the pulse
    bus.done_alu_1 = 1'b1; bus.tag_alu_1 = 4'd1; bus.value_alu_1 = 32'h11;
    applyStimulus();
    setIdle();
    bus.done_alu_2 = 1'b1; bus.tag_alu_2 = 4'd0; bus.value_alu_2 = 32'h22;
    applyStimulus();
    setIdle();
    #1;
    checkOutput("no_commit_same_cycle_wb", bus.commit, 1'b0);
    applyStimulus();
    #1;
    checkOutput("commit0", bus.commit, 1'b1);
    checkOutput("commit0_tag", bus.commit_tag, 4'd0);
    checkOutput("commit0_value", bus.commit_value, 32'h22);
    checkOutput("commit0_rd", bus.commit_rd, 5'd1);
    rdy_in = 1'b0;
    applyStimulus();
    #1;
    checkOutput("stall_hold_commit", bus.commit, 1'b1);
    checkOutput("stall_hold_tag", bus.commit_tag, 4'd0);
    rdy_in = 1'b1;
    applyStimulus();
    #1;
    checkOutput("commit1", bus.commit, 1'b1);
    checkOutput("commit1_tag", bus.commit_tag, 4'd1);
    checkOutput("commit1_value", bus.commit_value, 32'h11);
    applyStimulus();
    #1;
    checkOutput("commit_idle", bus.commit, 1'b0);

    // Fill, overflow attempt and wrap
    doReset();
    issueN(16);
    bus.issue = 1'b1;
    #1;
    checkOutput("full_16", bus.full, 1'b1);
    applyStimulus();
    setIdle();
    #1;
    checkOutput("full_after_17th", bus.full, 1'b1);
    checkOutput("tail_after_17th", bus.issue_tag, 4'd0);
    bus.done_alu_1 = 1'b1; bus.tag_alu_1 = 4'd0; bus.value_alu_1 = 32'h33;
    applyStimulus();
    setIdle();
    applyStimulus();
    #1;
    checkOutput("wrap_commit_tag", bus.commit_tag, 4'd0);
    checkOutput("full_freed", bus.full, 1'b0);
    bus.issue = 1'b1; bus.issue_rd = 5'd3;
    #1;
    checkOutput("wrap_issue_tag", bus.issue_tag, 4'd0);
    applyStimulus();
    setIdle();
    #1;
    checkOutput("full_again", bus.full, 1'b1);
    checkOutput("wrap_tail", bus.issue_tag, 4'd1);

    // Mispredicted branch at tag 2 flushes everything, including a same-cycle issue
    doReset();
    issueN(2);
    bus.issue = 1'b1; bus.issue_rd = 5'd7; bus.issue_is_branch = 1'b1; bus.issue_pred_taken = 1'b1;
    applyStimulus();
    setIdle();
    bus.done_alu_1 = 1'b1; bus.tag_alu_1 = 4'd0; bus.value_alu_1 = 32'h1;
    bus.done_alu_2 = 1'b1; bus.tag_alu_2 = 4'd1; bus.value_alu_2 = 32'h2;
    applyStimulus();
    setIdle();
    bus.done_alu_1 = 1'b1; bus.tag_alu_1 = 4'd2; bus.value_alu_1 = 32'h0;
    applyStimulus();
    setIdle();
    #1;
    checkOutput("pre_flush_clear", bus.clear_signal, 1'b0);
    applyStimulus();
    bus.issue = 1'b1; bus.issue_rd = 5'd9;
    applyStimulus();
    setIdle();
    #1;
    checkOutput("flush_commit", bus.commit, 1'b1);
    checkOutput("flush_clear", bus.clear_signal, 1'b1);
    checkOutput("flush_tag", bus.commit_tag, 4'd2);
    checkOutput("flush_rd", bus.commit_rd, 5'd0);
    checkOutput("flush_issue_tag", bus.issue_tag, 4'd0);
    applyStimulus();
    #1;
    checkOutput("clear_one_cycle", bus.clear_signal, 1'b0);

    // Dual write-back to one tag with bypass on both query ports
    doReset();
    issueN(6);
    bus.done_alu_1 = 1'b1; bus.tag_alu_1 = 4'd5; bus.value_alu_1 = 32'hA;
    bus.done_alu_2 = 1'b1; bus.tag_alu_2 = 4'd5; bus.value_alu_2 = 32'hB;
    bus.query_tag_1 = 4'd5; bus.query_tag_2 = 4'd5;
    #1;
    checkOutput("bypass_ready", bus.query_ready_1, 1'b1);
    checkOutput("bypass_value", bus.query_value_1, 32'hA);
    applyStimulus();
    setIdle();
    bus.query_tag_1 = 4'd5; bus.query_tag_2 = 4'd4;
    bus.done_alu_2 = 1'b1; bus.tag_alu_2 = 4'd5; bus.value_alu_2 = 32'hC;
    #1;
    checkOutput("stored_value", bus.query_value_1, 32'hA);
    checkOutput("other_not_ready", bus.query_ready_2, 1'b0);
    applyStimulus();
    setIdle();
    bus.query_tag_1 = 4'd5;
    #1;
    checkOutput("late_wb_ignored", bus.query_value_1, 32'hA);

    // Asynchronous reset between edges
    doReset();
    issueN(4);
    bus.done_alu_1 = 1'b1; bus.tag_alu_1 = 4'd0; bus.value_alu_1 = 32'h44;
    applyStimulus();
    setIdle();
    applyStimulus();
    #1;
    checkOutput("pre_reset_commit", bus.commit, 1'b1);
    rst_in = 1'b1;
    #1;
    checkOutput("async_commit", bus.commit, 1'b0);
    checkOutput("async_value", bus.commit_value, 32'h0);
    checkOutput("async_full", bus.full, 1'b0);
    checkOutput("async_issue_tag", bus.issue_tag, 4'd0);
    rst_in = 1'b0;
    repeat (3) applyStimulus();

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
